// File: rtl/ceespu_mem_arbiter_if.sv
// Fetch/data request, response and single-port memory bundle
// for the ceespu memory arbiter.
interface ceespu_mem_arbiter_if;
    logic        I_fetch_req;
    logic [13:0] I_fetch_addr;
    logic        O_fetch_grant;
    logic        O_fetch_valid;
    logic [31:0] O_fetch_data;
    logic        O_fetch_stall;

    logic        I_data_req;
    logic [3:0]  I_data_we;
    logic [31:0] I_data_addr;
    logic [31:0] I_data_wdata;
    logic        O_data_grant;
    logic        O_data_valid;
    logic [31:0] O_data_rdata;

    logic        O_mem_en;
    logic [3:0]  O_mem_we;
    logic [13:0] O_mem_addr;
    logic [31:0] O_mem_wdata;
    logic [31:0] I_mem_rdata;

    modport slave (
        input  I_fetch_req, I_fetch_addr,
        output O_fetch_grant, O_fetch_valid,
        output O_fetch_data, O_fetch_stall,
        input  I_data_req, I_data_we,
        input  I_data_addr, I_data_wdata,
        output O_data_grant, O_data_valid,
        output O_data_rdata,
        output O_mem_en, O_mem_we,
        output O_mem_addr, O_mem_wdata,
        input  I_mem_rdata
    );

    modport master (
        output I_fetch_req, I_fetch_addr,
        input  O_fetch_grant, O_fetch_valid,
        input  O_fetch_data, O_fetch_stall,
        output I_data_req, I_data_we,
        output I_data_addr, I_data_wdata,
        input  O_data_grant, O_data_valid,
        input  O_data_rdata,
        input  O_mem_en, O_mem_we,
        input  O_mem_addr, O_mem_wdata,
        output I_mem_rdata
    );
endinterface

// File: rtl/ceespu_mem_arbiter.sv
// Fetch/data arbiter for a single-port memory, fixed 1-cycle response.
// CEESPU_ARB_STARVE_EN enables the fetch starvation counter.
module ceespu_mem_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input logic I_clk,
    input logic I_rst_n,
    ceespu_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RSP_FETCH,
        RSP_DATA
    } state_t;

    state_t state_q, state_d;
    logic   gnt_f, gnt_d;
    logic   starved;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
        $error("STARVE_LIMIT must be 1..7");
    end

`ifdef CEESPU_ARB_STARVE_EN
    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);
    logic [2:0] cnt_q;

    assign starved = bus.I_fetch_req && bus.I_data_req
                     && (cnt_q == LIMIT);

    // Saturates: never wraps back below the limit while fetch waits.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            cnt_q <= 3'd0;
        end else if (!bus.I_fetch_req || gnt_f) begin
            cnt_q <= 3'd0;
        end else if (gnt_d && cnt_q != LIMIT) begin
            cnt_q <= cnt_q + 3'd1;
        end
    end
`else
    assign starved = 1'b0;
`endif

    logic [17:0] unused_addr;
    assign unused_addr = {bus.I_data_addr[31:16],
                          bus.I_data_addr[1:0]};

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        gnt_f   = 1'b0;
        gnt_d   = 1'b0;
        state_d = IDLE;
        // Grants are gated by reset so nothing reaches memory in reset.
        if (I_rst_n) begin
            gnt_f = bus.I_fetch_req
                    && (!bus.I_data_req || starved);
            gnt_d = bus.I_data_req && !gnt_f;
        end
        unique case (1'b1)
            gnt_f:   state_d = RSP_FETCH;
            gnt_d:   state_d = RSP_DATA;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.O_fetch_grant = gnt_f;
        bus.O_data_grant  = gnt_d;
        bus.O_fetch_stall = bus.I_fetch_req && !gnt_f;
        bus.O_mem_en      = gnt_f || gnt_d;
        bus.O_mem_we      = 4'b0000;
        bus.O_mem_addr    = bus.I_fetch_addr;
        bus.O_mem_wdata   = 32'd0;
        if (gnt_d) begin
            bus.O_mem_we    = bus.I_data_we;
            bus.O_mem_addr  = bus.I_data_addr[15:2];
            bus.O_mem_wdata = bus.I_data_wdata;
        end
    end

    always_comb begin
        bus.O_fetch_valid = (state_q == RSP_FETCH);
        bus.O_data_valid  = (state_q == RSP_DATA);
        bus.O_fetch_data  = 32'd0;
        bus.O_data_rdata  = 32'd0;
        if (state_q == RSP_FETCH) bus.O_fetch_data = bus.I_mem_rdata;
        if (state_q == RSP_DATA)  bus.O_data_rdata = bus.I_mem_rdata;
    end

endmodule

// File: tb/tb_ceespu_mem_arbiter.sv
// Bench for ceespu_mem_arbiter: request-level model plus directed vectors.
// Build with or without +define+CEESPU_ARB_STARVE_EN.
module tb_ceespu_mem_arbiter;

    localparam int LIM = 3;
    localparam int NONE = 0, OWN_F = 1, OWN_D = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ceespu_mem_arbiter_if mif();

    ceespu_mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .I_clk  (clk),
        .I_rst_n(rst_n),
        .bus    (mif.slave)
    );

    int checks = 0;
    int errors = 0;

    // Environment: write-first single-port memory.
    logic [31:0] mem     [0:16383];
    logic [31:0] ref_mem [0:16383];

    always @(posedge clk) begin
        if (mif.O_mem_en) begin
            logic [31:0] w;
            w = mem[mif.O_mem_addr];
            for (int b = 0; b < 4; b++)
                if (mif.O_mem_we[b]) w[b*8 +: 8] = mif.O_mem_wdata[b*8 +: 8];
            mem[mif.O_mem_addr] <= w;
            mif.I_mem_rdata <= w;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: who owns memory given the requests and the wait history.
    function automatic int owner(logic fr, logic dr, int c);
        if (fr && dr) begin
`ifdef CEESPU_ARB_STARVE_EN
            return (c >= LIM) ? OWN_F : OWN_D;
`else
            return OWN_D;
`endif
        end
        if (fr) return OWN_F;
        if (dr) return OWN_D;
        return NONE;
    endfunction

    int          m_cnt;
    int          pend;
    logic        pend_rd;
    logic [31:0] pend_data;

    function automatic int cur_owner();
        if (!rst_n) return NONE;
        return owner(mif.I_fetch_req, mif.I_data_req, m_cnt);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;
            pend  <= NONE;
        end else begin
            int o;
            logic [13:0] wa;
            logic [31:0] w;
            o = cur_owner();
            pend <= o;
            pend_rd <= (o == OWN_F) || (mif.I_data_we == 4'b0000);
            if (o == OWN_D && mif.I_fetch_req)
                m_cnt <= (m_cnt < LIM) ? m_cnt + 1 : m_cnt;
            else
                m_cnt <= 0;
            if (o == OWN_F) pend_data <= ref_mem[mif.I_fetch_addr];
            if (o == OWN_D) begin
                wa = mif.I_data_addr[15:2];
                w  = ref_mem[wa];
                for (int b = 0; b < 4; b++)
                    if (mif.I_data_we[b]) w[b*8 +: 8] = mif.I_data_wdata[b*8 +: 8];
                ref_mem[wa] <= w;
                pend_data <= w;
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        int o;
        o = cur_owner();
        chk("fetch_grant", 32'(mif.O_fetch_grant), 32'(o == OWN_F));
        chk("data_grant", 32'(mif.O_data_grant), 32'(o == OWN_D));
        chk("fetch_stall", 32'(mif.O_fetch_stall),
            32'(mif.I_fetch_req && o != OWN_F));
        chk("mem_en", 32'(mif.O_mem_en), 32'(o != NONE));
        chk("mem_we", 32'(mif.O_mem_we),
            32'((o == OWN_D) ? mif.I_data_we : 4'b0000));
        if (o == OWN_F)
            chk("mem_addr_f", 32'(mif.O_mem_addr), 32'(mif.I_fetch_addr));
        if (o == OWN_D) begin
            chk("mem_addr_d", 32'(mif.O_mem_addr),
                32'(mif.I_data_addr[15:2]));
            chk("mem_wdata", mif.O_mem_wdata, mif.I_data_wdata);
        end
        chk("fetch_valid", 32'(mif.O_fetch_valid), 32'(pend == OWN_F));
        chk("data_valid", 32'(mif.O_data_valid), 32'(pend == OWN_D));
        chk("fetch_data", mif.O_fetch_data,
            (pend == OWN_F) ? pend_data : 32'd0);
        if (pend != OWN_D || pend_rd)
            chk("data_rdata", mif.O_data_rdata,
                (pend == OWN_D) ? pend_data : 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mif.I_fetch_req  = 1'b0;
        mif.I_data_req   = 1'b0;
        mif.I_data_we    = 4'b0000;
        mif.I_data_wdata = 32'd0;
    endtask

    logic [7:0] pat;
    logic [7:0] pat_exp;

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem[i]     = {16'(i) ^ 16'hA5A5, 16'(i)};
            ref_mem[i] = {16'(i) ^ 16'hA5A5, 16'(i)};
        end
        mem[16'h10]     = 32'hDEADBEEF;
        ref_mem[16'h10] = 32'hDEADBEEF;
        mem[16'h40]     = 32'h11223344;
        ref_mem[16'h40] = 32'h11223344;
        mif.I_mem_rdata  = 32'd0;
        mif.I_fetch_addr = 14'd0;
        mif.I_data_addr  = 32'd0;
        idle();
        rst_n = 1'b0;
        mif.I_fetch_req = 1'b1;
        mif.I_data_req  = 1'b1;
        @(negedge clk);
        chk("rst_grant", 32'({mif.O_fetch_grant, mif.O_data_grant}), 32'd0);
        chk("rst_en", 32'(mif.O_mem_en), 32'd0);
        step();
        idle();
        step();
        rst_n = 1'b1;

        // Fetch only; request drops after the grant.
        mif.I_fetch_req  = 1'b1;
        mif.I_fetch_addr = 14'h0010;
        @(negedge clk);
        chk("f36_grant", 32'(mif.O_fetch_grant), 32'd1);
        step();
        idle();
        @(negedge clk);
        chk("f36_valid", 32'(mif.O_fetch_valid), 32'd1);
        chk("f36_data", mif.O_fetch_data, 32'hDEADBEEF);
        step();

        // Both requesting: data wins, fetch next cycle.
        mif.I_fetch_req  = 1'b1;
        mif.I_fetch_addr = 14'h0020;
        mif.I_data_req   = 1'b1;
        mif.I_data_addr  = 32'h0000_0044;
        @(negedge clk);
        chk("d37_grant", 32'(mif.O_data_grant), 32'd1);
        chk("d37_addr", 32'(mif.O_mem_addr), 32'h0011);
        chk("d37_stall", 32'(mif.O_fetch_stall), 32'd1);
        step();
        mif.I_data_req = 1'b0;
        @(negedge clk);
        chk("d37_fgrant", 32'(mif.O_fetch_grant), 32'd1);
        chk("d37_dvalid", 32'(mif.O_data_valid), 32'd1);
        step();
        idle();

        // Byte store then read back in the next cycle.
        mif.I_data_req   = 1'b1;
        mif.I_data_we    = 4'b0100;
        mif.I_data_addr  = 32'h0000_0102;
        mif.I_data_wdata = 32'h5A5A5A5A;
        step();
        mif.I_data_we   = 4'b0000;
        mif.I_data_addr = 32'h0000_0100;
        @(negedge clk);
        chk("s38_wack", 32'(mif.O_data_valid), 32'd1);
        step();
        idle();
        @(negedge clk);
        chk("s38_rdata", mif.O_data_rdata, 32'h115A3344);
        step();

        // Back-to-back mixed traffic, upper address bits ignored.
        for (int i = 0; i < 6; i++) begin
            mif.I_fetch_req  = i[0];
            mif.I_fetch_addr = 14'(16'h0100 + i);
            mif.I_data_req   = (i % 3) != 2;
            mif.I_data_we    = (i == 1) ? 4'b1111 : 4'b0000;
            mif.I_data_addr  = 32'hFFFF_0200 + 32'(i * 4) + 32'(i & 3);
            mif.I_data_wdata = 32'hC0DE_0000 + 32'(i);
            step();
        end
        idle();
        step();

        // Starvation pattern over 8 cycles of contention.
        mif.I_fetch_req  = 1'b1;
        mif.I_fetch_addr = 14'h0030;
        mif.I_data_req   = 1'b1;
        mif.I_data_addr  = 32'h0000_0200;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pat[i] = mif.O_fetch_grant;
            step();
        end
`ifdef CEESPU_ARB_STARVE_EN
        pat_exp = 8'b1000_1000;
`else
        pat_exp = 8'b0000_0000;
`endif
        chk("s39_pattern", 32'(pat), 32'(pat_exp));
        idle();
        step();

        // Reset lands on a pending data response.
        mif.I_data_req  = 1'b1;
        mif.I_data_addr = 32'h0000_0044;
        @(negedge clk);
        chk("r40_grant", 32'(mif.O_data_grant), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r40_async_en", 32'(mif.O_mem_en), 32'd0);
        chk("r40_async_g", 32'(mif.O_data_grant), 32'd0);
        @(negedge clk);
        chk("r40_no_valid", 32'(mif.O_data_valid), 32'd0);
        chk("r40_rdata", mif.O_data_rdata, 32'd0);
        step();
        idle();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("r40_post_valid", 32'(mif.O_data_valid), 32'd0);
        step();
        mif.I_fetch_req  = 1'b1;
        mif.I_fetch_addr = 14'h0010;
        @(negedge clk);
        chk("r40_resume_g", 32'(mif.O_fetch_grant), 32'd1);
        step();
        idle();
        @(negedge clk);
        chk("r40_resume_d", mif.O_fetch_data, 32'hDEADBEEF);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
